// File: rtl/ppheavy_pkg.sv
// Shared definitions for the ppheavy power-on sequencer: state encoding,
// default timing values and the watchdog counter width.
package ppheavy_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARMED    = 3'd1,
        STAGE1   = 3'd2,
        ON       = 3'd3,
        FAULT    = 3'd4,
        OFF_WAIT = 3'd5
    } seq_state_t;

    localparam int TIMEOUT_TICKS_DEF = 40;
    localparam int MIN_GAP_TICKS_DEF = 8;
    localparam int OFF_GAP_TICKS_DEF = 10;
    localparam int WDOG_W            = 7;

endpackage

// File: rtl/ppheavy_wdog.sv
// Clearable, saturating tick counter for the ppheavy sequencer watchdog.
// at_limit is high whenever the count has reached LIMIT.
module ppheavy_wdog #(
    parameter int WIDTH = 7,
    parameter int LIMIT = 39
) (
    input  logic             clk_10k,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] MAX_W   = '1;

    // Count enabled ticks, holding at all-ones instead of wrapping back to zero.
    always_ff @(posedge clk_10k) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (en && (count != MAX_W)) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count >= LIMIT_W);

endmodule

// File: rtl/ppheavy_on_sequencer.sv
// ppheavy power-on sequencer: raises state_start toward the on-timer, counts
// the returned start pulses, steps stage1/stage2 enables and supervises the
// handshake with a timeout watchdog.
// Optional macro PPHEAVY_SEQ_OFF_DELAY_EN: ordered shutdown from ON, where
// stage2 drops first and stage1 follows OFF_GAP_TICKS ticks later.
module ppheavy_on_sequencer
    import ppheavy_pkg::*;
#(
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
    parameter int MIN_GAP_TICKS = MIN_GAP_TICKS_DEF
) (
    input  logic clk_10k,
    input  logic rst_n,
    input  logic power_req,
    input  logic start,
    output logic state_start,
    output logic stage1_en,
    output logic stage2_en,
    output logic seq_done,
    output logic seq_fault
);

    localparam logic [WDOG_W-1:0] MIN_GAP_W = WDOG_W'(MIN_GAP_TICKS);
`ifdef PPHEAVY_SEQ_OFF_DELAY_EN
    localparam logic [WDOG_W-1:0] OFF_LAST_W = WDOG_W'(OFF_GAP_TICKS_DEF - 1);
`endif

    seq_state_t        state_q;
    seq_state_t        state_d;
    logic [WDOG_W-1:0] wdog;
    logic              wdog_timeout;
    logic              wdog_clear;
    logic              wdog_en;
    logic              gap_ok;
    logic              state_start_d;
    logic              stage1_en_d;
    logic              stage2_en_d;
    logic              seq_done_d;
    logic              seq_fault_d;

    // The watchdog restarts from zero on every state change; in OFF_WAIT it
    // doubles as the stage1 release timer.
    assign wdog_clear = (state_d != state_q);
`ifdef PPHEAVY_SEQ_OFF_DELAY_EN
    assign wdog_en = (state_q == ARMED) || (state_q == STAGE1) || (state_q == OFF_WAIT);
`else
    assign wdog_en = (state_q == ARMED) || (state_q == STAGE1);
`endif
    assign gap_ok = (wdog >= MIN_GAP_W);

    ppheavy_wdog #(
        .WIDTH (WDOG_W),
        .LIMIT (TIMEOUT_TICKS - 1)
    ) u_wdog (
        .clk_10k  (clk_10k),
        .rst_n    (rst_n),
        .clear    (wdog_clear),
        .en       (wdog_en),
        .count    (wdog),
        .at_limit (wdog_timeout)
    );

    // Register the state and the outputs decoded from the upcoming state.
    always_ff @(posedge clk_10k) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            state_start <= 1'b0;
            stage1_en   <= 1'b0;
            stage2_en   <= 1'b0;
            seq_done    <= 1'b0;
            seq_fault   <= 1'b0;
        end else begin
            state_q     <= state_d;
            state_start <= state_start_d;
            stage1_en   <= stage1_en_d;
            stage2_en   <= stage2_en_d;
            seq_done    <= seq_done_d;
            seq_fault   <= seq_fault_d;
        end
    end

    // Next state: a power request drop beats a start pulse, and a start pulse
    // beats a timeout arriving in the same tick.
    always_comb begin
        state_d       = state_q;
        state_start_d = 1'b0;
        stage1_en_d   = 1'b0;
        stage2_en_d   = 1'b0;
        seq_done_d    = 1'b0;
        seq_fault_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (power_req) state_d = ARMED;
            end
            ARMED: begin
                if (!power_req)        state_d = IDLE;
                else if (start)        state_d = STAGE1;
                else if (wdog_timeout) state_d = FAULT;
            end
            STAGE1: begin
                if (!power_req)        state_d = IDLE;
                else if (start)        state_d = gap_ok ? ON : FAULT;
                else if (wdog_timeout) state_d = FAULT;
            end
            ON: begin
`ifdef PPHEAVY_SEQ_OFF_DELAY_EN
                if (!power_req) state_d = OFF_WAIT;
`else
                if (!power_req) state_d = IDLE;
`endif
            end
            FAULT: begin
                if (!power_req) state_d = IDLE;
            end
`ifdef PPHEAVY_SEQ_OFF_DELAY_EN
            OFF_WAIT: begin
                if (wdog >= OFF_LAST_W) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        case (state_d)
            ARMED: begin
                state_start_d = 1'b1;
            end
            STAGE1: begin
                state_start_d = 1'b1;
                stage1_en_d   = 1'b1;
            end
            ON: begin
                stage1_en_d = 1'b1;
                stage2_en_d = 1'b1;
                seq_done_d  = 1'b1;
            end
            FAULT: begin
                seq_fault_d = 1'b1;
            end
            OFF_WAIT: begin
                stage1_en_d = 1'b1;
            end
            default: begin
                state_start_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ppheavy_on_sequencer.sv
// Self-checking bench for ppheavy_on_sequencer. Each vector row drives
// {power_req, start, rst_n} for a number of ticks and states the outputs
// {state_start, stage1_en, stage2_en, seq_done, seq_fault} expected after
// every one of those ticks; expectations go through a scoreboard queue.
module tb_ppheavy_on_sequencer;

    logic clk_10k = 1'b0;
    logic rst_n;
    logic power_req;
    logic start;
    logic state_start;
    logic stage1_en;
    logic stage2_en;
    logic seq_done;
    logic seq_fault;

    typedef struct {
        logic       pr;
        logic       st;
        logic       rn;
        int         reps;
        logic [4:0] exp;
    } vec_t;

    localparam logic [4:0] O_IDLE = 5'b00000;
    localparam logic [4:0] O_ARM  = 5'b10000;
    localparam logic [4:0] O_ST1  = 5'b11000;
    localparam logic [4:0] O_ON   = 5'b01110;
    localparam logic [4:0] O_FLT  = 5'b00001;
    localparam logic [4:0] O_OFFW = 5'b01000;

    vec_t       vecs[$];
    logic [4:0] expQ[$];
    int         checks = 0;
    int         errors = 0;
    int         step   = 0;
    string      phase  = "init";

    ppheavy_on_sequencer dut (
        .clk_10k     (clk_10k),
        .rst_n       (rst_n),
        .power_req   (power_req),
        .start       (start),
        .state_start (state_start),
        .stage1_en   (stage1_en),
        .stage2_en   (stage2_en),
        .seq_done    (seq_done),
        .seq_fault   (seq_fault)
    );

    always #5 clk_10k = ~clk_10k;

    task automatic addVec(input logic pr, input logic st, input logic rn,
                          input int reps, input logic [4:0] exp);
        vec_t v;
        v.pr   = pr;
        v.st   = st;
        v.rn   = rn;
        v.reps = reps;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    task automatic checkOutput();
        logic [4:0] act;
        logic [4:0] exp;
        act = {state_start, stage1_en, stage2_en, seq_done, seq_fault};
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s step %0d: scoreboard empty, got %b", phase, step, act);
        end else begin
            exp = expQ.pop_front();
            if (act !== exp) begin
                errors++;
                $display("[TB] FAIL %s step %0d: {ss,s1,s2,done,flt} got %b, expected %b",
                         phase, step, act, exp);
            end
        end
        step++;
    endtask

    task automatic applyStimulus(input logic pr, input logic st, input logic rn,
                                 input logic [4:0] exp);
        @(negedge clk_10k);
        power_req = pr;
        start     = st;
        rst_n     = rn;
        expQ.push_back(exp);
        @(posedge clk_10k);
        #1;
        checkOutput();
    endtask

    task automatic runTable(input string name);
        phase = name;
        step  = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                applyStimulus(vecs[i].pr, vecs[i].st, vecs[i].rn, vecs[i].exp);
            end
        end
        vecs.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL sim_timeout: run did not complete, got no end, expected end");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        rst_n     = 1'b0;
        power_req = 1'b0;
        start     = 1'b0;

        addVec(1'b1, 1'b0, 1'b0, 3, O_IDLE);
        addVec(1'b0, 1'b0, 1'b1, 2, O_IDLE);
        runTable("reset");

        addVec(1'b1, 1'b0, 1'b1, 21, O_ARM);
        addVec(1'b1, 1'b1, 1'b1, 1,  O_ST1);
        addVec(1'b1, 1'b0, 1'b1, 14, O_ST1);
        addVec(1'b1, 1'b1, 1'b1, 1,  O_ON);
        addVec(1'b1, 1'b0, 1'b1, 4,  O_ON);
        addVec(1'b1, 1'b1, 1'b1, 1,  O_ON);
        addVec(1'b1, 1'b0, 1'b1, 2,  O_ON);
        runTable("nominal");

        phase = "reset_in_on";
        applyStimulus(1'b1, 1'b0, 1'b0, O_IDLE);
        applyStimulus(1'b0, 1'b0, 1'b1, O_IDLE);

        addVec(1'b1, 1'b0, 1'b1, 40, O_ARM);
        addVec(1'b1, 1'b0, 1'b1, 6,  O_FLT);
        addVec(1'b0, 1'b0, 1'b1, 1,  O_IDLE);
        addVec(1'b0, 1'b1, 1'b1, 1,  O_IDLE);
        addVec(1'b0, 1'b0, 1'b1, 2,  O_IDLE);
        runTable("armed_timeout");

        addVec(1'b1, 1'b0, 1'b1, 21, O_ARM);
        addVec(1'b1, 1'b1, 1'b1, 1,  O_ST1);
        addVec(1'b1, 1'b0, 1'b1, 2,  O_ST1);
        addVec(1'b1, 1'b1, 1'b1, 1,  O_FLT);
        addVec(1'b1, 1'b0, 1'b1, 2,  O_FLT);
        addVec(1'b0, 1'b0, 1'b1, 1,  O_IDLE);
        runTable("short_gap");

        addVec(1'b1, 1'b0, 1'b1, 21, O_ARM);
        addVec(1'b1, 1'b1, 1'b1, 1,  O_ST1);
        addVec(1'b1, 1'b0, 1'b1, 8,  O_ST1);
        addVec(1'b1, 1'b1, 1'b1, 1,  O_ON);
        addVec(1'b1, 1'b0, 1'b1, 2,  O_ON);
`ifdef PPHEAVY_SEQ_OFF_DELAY_EN
        addVec(1'b0, 1'b0, 1'b1, 3,  O_OFFW);
        addVec(1'b1, 1'b0, 1'b1, 7,  O_OFFW);
        addVec(1'b1, 1'b0, 1'b1, 1,  O_IDLE);
        addVec(1'b0, 1'b0, 1'b1, 1,  O_IDLE);
`else
        addVec(1'b0, 1'b0, 1'b1, 1,  O_IDLE);
        addVec(1'b0, 1'b0, 1'b1, 2,  O_IDLE);
`endif
        runTable("min_gap_and_powerdown");

        addVec(1'b1, 1'b0, 1'b1, 21, O_ARM);
        addVec(1'b1, 1'b1, 1'b1, 1,  O_ST1);
        addVec(1'b1, 1'b0, 1'b1, 1,  O_ST1);
        addVec(1'b0, 1'b0, 1'b1, 1,  O_IDLE);
        addVec(1'b0, 1'b1, 1'b1, 1,  O_IDLE);
        addVec(1'b0, 1'b0, 1'b1, 1,  O_IDLE);
        runTable("abort");

        addVec(1'b1, 1'b0, 1'b1, 21, O_ARM);
        addVec(1'b1, 1'b1, 1'b1, 1,  O_ST1);
        addVec(1'b1, 1'b0, 1'b1, 14, O_ST1);
        addVec(1'b0, 1'b1, 1'b1, 1,  O_IDLE);
        addVec(1'b0, 1'b0, 1'b1, 2,  O_IDLE);
        runTable("pulse_vs_drop");

        addVec(1'b1, 1'b0, 1'b1, 40, O_ARM);
        addVec(1'b1, 1'b1, 1'b1, 1,  O_ST1);
        addVec(1'b1, 1'b0, 1'b1, 3,  O_ST1);
        addVec(1'b0, 1'b0, 1'b1, 1,  O_IDLE);
        runTable("pulse_vs_timeout");

        addVec(1'b1, 1'b0, 1'b1, 21, O_ARM);
        addVec(1'b1, 1'b1, 1'b1, 1,  O_ST1);
        addVec(1'b1, 1'b0, 1'b1, 39, O_ST1);
        addVec(1'b1, 1'b0, 1'b1, 1,  O_FLT);
        addVec(1'b0, 1'b0, 1'b1, 1,  O_IDLE);
        runTable("stage1_timeout");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
